// File: rtl/des_key_rotator.sv
// DES key-schedule round engine: loads a C||D key pair and streams one rotated
// C||D value per round, in encrypt (rotate-left) or decrypt (rotate-right) order.
module des_key_rotator #(
   parameter int unsigned W              = 28,
   parameter int unsigned ROUNDS         = 16,
   parameter logic [15:0] ONE_SHIFT_MASK = 16'h8103
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            decrypt,
   input  logic            abort,
   input  logic [2*W-1:0]  key_in,
   input  logic            out_ready,
   output logic            out_valid,
   output logic [2*W-1:0]  cd_out,
   output logic [3:0]      round_out,
   output logic            busy,
   output logic            done
);

   localparam int unsigned CDW  = 2 * W;
   localparam logic [3:0]  LAST = 4'(ROUNDS - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q;
   logic [CDW-1:0]   cd_q;
   logic [3:0]       round_q;
   logic             dec_q;
   logic             valid_q;
   logic             busy_q;
   logic             done_q;

   logic [3:0]       next_round_d;
   logic [3:0]       dec_idx_d;
   logic             two_step_d;
   logic [CDW-1:0]   cd_step_d;
   logic [CDW-1:0]   cd_load_d;
   logic             accept_d;

   // Each half wraps on itself; no bits cross between C and D.
   function automatic logic [W-1:0] rotl_half(input logic [W-1:0] x, input logic two);
      return two ? ((x << 2) | (x >> (W - 2))) : ((x << 1) | (x >> (W - 1)));
   endfunction

   function automatic logic [W-1:0] rotr_half(input logic [W-1:0] x, input logic two);
      return two ? ((x >> 2) | (x << (W - 2))) : ((x >> 1) | (x << (W - 1)));
   endfunction

   function automatic logic [CDW-1:0] rotl_pair(input logic [CDW-1:0] x, input logic two);
      return {rotl_half(x[CDW-1:W], two), rotl_half(x[W-1:0], two)};
   endfunction

   function automatic logic [CDW-1:0] rotr_pair(input logic [CDW-1:0] x, input logic two);
      return {rotr_half(x[CDW-1:W], two), rotr_half(x[W-1:0], two)};
   endfunction

   // Decrypt walks the shift table backwards: round i undoes shift s(ROUNDS-i).
   always_comb begin
      next_round_d = round_q + 4'd1;
      dec_idx_d    = 4'(5'(ROUNDS) - {1'b0, next_round_d});
      two_step_d   = dec_q ? !ONE_SHIFT_MASK[dec_idx_d] : !ONE_SHIFT_MASK[next_round_d];
      cd_step_d    = dec_q ? rotr_pair(cd_q, two_step_d) : rotl_pair(cd_q, two_step_d);
      cd_load_d    = decrypt ? key_in : rotl_pair(key_in, !ONE_SHIFT_MASK[0]);
      accept_d     = valid_q & out_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cd_q    <= '0;
         round_q <= '0;
         dec_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= RUN;
                  cd_q    <= cd_load_d;
                  round_q <= '0;
                  dec_q   <= decrypt;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            RUN: begin
               // abort wins over a beat accepted on the same edge
               if (abort) begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
               end else if (accept_d) begin
                  if (round_q == LAST) begin
                     state_q <= IDLE;
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     cd_q    <= cd_step_d;
                     round_q <= next_round_d;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_valid = valid_q;
   assign cd_out    = cd_q;
   assign round_out = round_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_des_key_rotator.sv
// Scoreboard bench for des_key_rotator: default DES instance plus a small
// W=8 / ROUNDS=4 instance.
module tb_des_key_rotator;

   localparam logic [15:0] MASK = 16'h8103;

   typedef struct packed {
      logic [55:0] cd;
      logic [3:0]  rnd;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, decrypt = 1'b0, abort = 1'b0, out_ready = 1'b0;
   logic [55:0] key_in = '0;
   logic        out_valid, busy, done;
   logic [55:0] cd_out;
   logic [3:0]  round_out;

   logic        s_start = 1'b0, s_decrypt = 1'b0, s_abort = 1'b0, s_out_ready = 1'b0;
   logic [15:0] s_key_in = '0;
   logic        s_out_valid, s_busy, s_done;
   logic [15:0] s_cd_out;
   logic [3:0]  s_round_out;

   int          vectors = 0;
   int          miscompares = 0;
   beat_t       exp_q[$];
   logic [55:0] enc_ref [16];

   always #5 clk = ~clk;

   des_key_rotator u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .abort(abort),
      .key_in(key_in), .out_ready(out_ready), .out_valid(out_valid), .cd_out(cd_out),
      .round_out(round_out), .busy(busy), .done(done));

   des_key_rotator #(.W(8), .ROUNDS(4), .ONE_SHIFT_MASK(16'h0005)) u_small (
      .clk(clk), .rst_n(rst_n), .start(s_start), .decrypt(s_decrypt), .abort(s_abort),
      .key_in(s_key_in), .out_ready(s_out_ready), .out_valid(s_out_valid), .cd_out(s_cd_out),
      .round_out(s_round_out), .busy(s_busy), .done(s_done));

   function automatic logic [27:0] rot(input logic [27:0] x, input int n, input bit left);
      for (int j = 0; j < n; j++) x = left ? {x[26:0], x[27]} : {x[0], x[27:1]};
      return x;
   endfunction

   function automatic int sh(input int i);
      return MASK[i] ? 1 : 2;
   endfunction

   // Reference sequence built bit-by-bit from the round definitions.
   task automatic push_sweep(input logic [55:0] key, input bit dec);
      logic [27:0] c, d;
      beat_t b;
      c = key[55:28];
      d = key[27:0];
      for (int i = 0; i < 16; i++) begin
         if (!dec) begin
            c = rot(c, sh(i), 1'b1);
            d = rot(d, sh(i), 1'b1);
         end else if (i > 0) begin
            c = rot(c, sh(16 - i), 1'b0);
            d = rot(d, sh(16 - i), 1'b0);
         end
         b.cd  = {c, d};
         b.rnd = 4'(i);
         exp_q.push_back(b);
         if (!dec) enc_ref[i] = {c, d};
      end
   endtask

   task automatic kick(input logic [55:0] key, input bit dec);
      key_in  = key;
      decrypt = dec;
      start   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
   endtask

   task automatic test_reset;
      #2;
      vectors++;
      if ({out_valid, cd_out, round_out, busy, done} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got v=%b cd=%h r=%0d b=%b d=%b expected all zero",
                  out_valid, cd_out, round_out, busy, done);
      end
      vectors++;
      if ({s_out_valid, s_cd_out, s_round_out, s_busy, s_done} !== '0) begin
         miscompares++;
         $display("FAIL reset_small: got v=%b cd=%h r=%0d expected all zero",
                  s_out_valid, s_cd_out, s_round_out);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_encrypt;
      int beats = 0, cyc = 0;
      beat_t e;
      push_sweep(56'h0000001_8000000, 1'b0);
      out_ready = 1'b1;
      kick(56'h0000001_8000000, 1'b0);
      while (beats < 16 && cyc < 40) begin
         if (out_valid) begin
            e = exp_q.pop_front();
            vectors++;
            if (cd_out !== e.cd || round_out !== e.rnd) begin
               miscompares++;
               $display("FAIL enc_beat: got r=%0d cd=%h expected r=%0d cd=%h", round_out, cd_out, e.rnd, e.cd);
            end
            if (round_out == 4'd0 || round_out == 4'd2 || round_out == 4'd15) begin
               vectors++;
               if ((round_out == 4'd0  && cd_out !== 56'h0000002_0000001) ||
                   (round_out == 4'd2  && cd_out !== 56'h0000010_0000008) ||
                   (round_out == 4'd15 && cd_out !== 56'h0000001_8000000)) begin
                  miscompares++;
                  $display("FAIL enc_const: round %0d got %h", round_out, cd_out);
               end
            end
            beats++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      vectors++;
      if (cyc !== 16) begin
         miscompares++;
         $display("FAIL enc_throughput: got %0d cycles expected 16", cyc);
      end
      vectors++;
      if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL enc_done: got done=%b valid=%b busy=%b expected 1 0 0", done, out_valid, busy);
      end
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b0) begin
         miscompares++;
         $display("FAIL enc_done_pulse: got done=%b expected 0", done);
      end
   endtask

   task automatic test_decrypt;
      int beats = 0, cyc = 0;
      beat_t e;
      push_sweep(56'h0000001_8000000, 1'b1);
      out_ready = 1'b1;
      kick(56'h0000001_8000000, 1'b1);
      while (beats < 16 && cyc < 40) begin
         if (out_valid) begin
            e = exp_q.pop_front();
            vectors++;
            if (cd_out !== e.cd || round_out !== e.rnd || cd_out !== enc_ref[15 - beats]) begin
               miscompares++;
               $display("FAIL dec_beat: got r=%0d cd=%h expected r=%0d cd=%h enc_mirror=%h",
                        round_out, cd_out, e.rnd, e.cd, enc_ref[15 - beats]);
            end
            if (round_out <= 4'd1) begin
               vectors++;
               if ((round_out == 4'd0 && cd_out !== 56'h0000001_8000000) ||
                   (round_out == 4'd1 && cd_out !== 56'h8000000_4000000)) begin
                  miscompares++;
                  $display("FAIL dec_const: round %0d got %h", round_out, cd_out);
               end
            end
            beats++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      vectors++;
      if (beats !== 16 || done !== 1'b1) begin
         miscompares++;
         $display("FAIL dec_done: got beats=%0d done=%b expected 16 1", beats, done);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure;
      int beats = 0, cyc = 0;
      bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      beat_t e;
      push_sweep(56'h0000001_8000000, 1'b0);
      out_ready = 1'b1;
      kick(56'h0000001_8000000, 1'b0);
      while (beats < 16 && cyc < 100) begin
         out_ready = pat[cyc % 4];
         if (out_valid) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL bp_extra: got unexpected beat r=%0d", round_out);
            end else begin
               e = exp_q[0];
               if (cd_out !== e.cd || round_out !== e.rnd) begin
                  miscompares++;
                  $display("FAIL bp_beat: stall=%b got r=%0d cd=%h expected r=%0d cd=%h",
                           !out_ready, round_out, cd_out, e.rnd, e.cd);
               end
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  beats++;
               end
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      out_ready = 1'b1;
      vectors++;
      if (beats !== 16 || done !== 1'b1 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_done: got beats=%0d done=%b valid=%b expected 16 1 0", beats, done, out_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_abort;
      int cyc = 0;
      beat_t e;
      push_sweep(56'h0123456_789ABCD, 1'b0);
      out_ready = 1'b1;
      kick(56'h0123456_789ABCD, 1'b0);
      while (cyc < 40) begin
         if (out_valid) begin
            e = exp_q.pop_front();
            vectors++;
            if (cd_out !== e.cd || round_out !== e.rnd) begin
               miscompares++;
               $display("FAIL abort_pre: got r=%0d cd=%h expected r=%0d cd=%h", round_out, cd_out, e.rnd, e.cd);
            end
            if (round_out == 4'd5) break;
         end
         @(posedge clk); #1;
         cyc++;
      end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_idle: got valid=%b busy=%b done=%b expected 0 0 0", out_valid, busy, done);
      end
      exp_q.delete();
      push_sweep(56'hFEDCBA9_8765432, 1'b0);
      kick(56'hFEDCBA9_8765432, 1'b0);
      for (int k = 0; k < 2; k++) begin
         e = exp_q.pop_front();
         vectors++;
         if (out_valid !== 1'b1 || cd_out !== e.cd || round_out !== e.rnd) begin
            miscompares++;
            $display("FAIL abort_restart: got v=%b r=%0d cd=%h expected r=%0d cd=%h",
                     out_valid, round_out, cd_out, e.rnd, e.cd);
         end
         @(posedge clk); #1;
      end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset_midrun;
      int cyc = 0;
      beat_t e;
      push_sweep(56'h0A5A5A5_5A5A5A5, 1'b0);
      out_ready = 1'b1;
      kick(56'h0A5A5A5_5A5A5A5, 1'b0);
      while (cyc < 40) begin
         if (out_valid) begin
            e = exp_q.pop_front();
            vectors++;
            if (cd_out !== e.cd || round_out !== e.rnd) begin
               miscompares++;
               $display("FAIL rst_pre: got r=%0d cd=%h expected r=%0d cd=%h", round_out, cd_out, e.rnd, e.cd);
            end
            if (round_out == 4'd9) break;
         end
         // a start while running must not disturb the sequence
         if (round_out == 4'd3) begin
            start = 1'b1; decrypt = 1'b1; key_in = 56'hFFFFFFF_0000000;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      rst_n = 1'b0;
      #2;
      vectors++;
      if ({out_valid, cd_out, round_out, busy, done} !== '0) begin
         miscompares++;
         $display("FAIL rst_async: got v=%b cd=%h r=%0d b=%b d=%b expected all zero",
                  out_valid, cd_out, round_out, busy, done);
      end
      @(posedge clk); #1;
      vectors++;
      if ({out_valid, cd_out, round_out, busy, done} !== '0) begin
         miscompares++;
         $display("FAIL rst_hold: got v=%b cd=%h r=%0d b=%b d=%b expected all zero",
                  out_valid, cd_out, round_out, busy, done);
      end
      rst_n = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      push_sweep(56'h1111111_2222222, 1'b0);
      kick(56'h1111111_2222222, 1'b0);
      e = exp_q.pop_front();
      vectors++;
      if (out_valid !== 1'b1 || round_out !== 4'd0 || cd_out !== e.cd) begin
         miscompares++;
         $display("FAIL rst_restart: got v=%b r=%0d cd=%h expected 1 0 %h", out_valid, round_out, cd_out, e.cd);
      end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_param_variant;
      logic [15:0] sq[$];
      logic [15:0] ex;
      int beats = 0, cyc = 0;
      sq = '{16'h03_02, 16'h0C_08, 16'h18_10, 16'h60_40};
      s_out_ready = 1'b1;
      s_key_in    = 16'h81_01;
      s_decrypt   = 1'b0;
      s_start     = 1'b1;
      @(posedge clk); #1;
      s_start     = 1'b0;
      while (beats < 4 && cyc < 20) begin
         if (s_out_valid) begin
            ex = sq.pop_front();
            vectors++;
            if (s_cd_out !== ex || s_round_out !== 4'(beats)) begin
               miscompares++;
               $display("FAIL small_beat: got r=%0d cd=%h expected r=%0d cd=%h", s_round_out, s_cd_out, beats, ex);
            end
            beats++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      vectors++;
      if (beats !== 4 || s_done !== 1'b1 || s_out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL small_done: got beats=%0d done=%b valid=%b expected 4 1 0", beats, s_done, s_out_valid);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_encrypt();
      test_decrypt();
      test_backpressure();
      test_abort();
      test_reset_midrun();
      test_param_variant();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
